// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder front end: FSM state encoding and default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int SER_WIDTH = 8;

endpackage

// File: rtl/operand_serializer.sv
// Accepts A/B operand pairs and streams them LSB first, one bit per cycle, to a bit-serial adder.
// Define OPERAND_SERIALIZER_FRAME_GAP_EN to insert one idle cycle between consecutive frames.
module operand_serializer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             en_i,
  output logic             in1,
  output logic             in2,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sr_a, r_sr_b, r_hr_a, r_hr_b;
  logic             r_hr_full, r_en, r_in1, r_in2;
  logic             w_acc, w_load, w_from_hr, w_shift, w_stop, w_hr_wr, w_hr_clr;
  logic [WIDTH-1:0] w_src_a, w_src_b;

  assign w_acc    = op_valid && !r_hr_full;
  assign w_src_a  = w_from_hr ? r_hr_a : op_a;
  assign w_src_b  = w_from_hr ? r_hr_b : op_b;
  assign op_ready = !r_hr_full;
  assign busy     = (r_state != IDLE) || r_hr_full;
  assign en_i     = r_en;
  assign in1      = r_in1;
  assign in2      = r_in2;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_from_hr   = 1'b0;
    w_shift     = 1'b0;
    w_stop      = 1'b0;
    w_hr_wr     = 1'b0;
    w_hr_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != LAST) begin
          w_shift = 1'b1;
          w_hr_wr = w_acc;
        end else begin
`ifdef OPERAND_SERIALIZER_FRAME_GAP_EN
          // A word taken on the last bit waits in HR through the gap cycle
          w_stop  = 1'b1;
          w_hr_wr = w_acc;
          if (r_hr_full || w_acc) w_state_nxt = GAP;
          else                    w_state_nxt = IDLE;
`else
          if (r_hr_full) begin
            w_load    = 1'b1;
            w_from_hr = 1'b1;
            w_hr_clr  = 1'b1;
            w_hr_wr   = w_acc;
          end else if (w_acc) begin
            w_load = 1'b1;
          end else begin
            w_stop      = 1'b1;
            w_state_nxt = IDLE;
          end
`endif
        end
      end
`ifdef OPERAND_SERIALIZER_FRAME_GAP_EN
      GAP: begin
        w_state_nxt = SHIFT;
        w_load      = 1'b1;
        w_from_hr   = 1'b1;
        w_hr_clr    = 1'b1;
        w_hr_wr     = w_acc;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Bit 0 goes straight to the output register on load; SR keeps the remaining bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sr_a    <= '0;
      r_sr_b    <= '0;
      r_hr_a    <= '0;
      r_hr_b    <= '0;
      r_hr_full <= 1'b0;
      r_en      <= 1'b0;
      r_in1     <= 1'b0;
      r_in2     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_en   <= 1'b1;
        r_in1  <= w_src_a[0];
        r_in2  <= w_src_b[0];
        r_sr_a <= w_src_a >> 1;
        r_sr_b <= w_src_b >> 1;
        r_cnt  <= '0;
      end else if (w_shift) begin
        r_in1  <= r_sr_a[0];
        r_in2  <= r_sr_b[0];
        r_sr_a <= r_sr_a >> 1;
        r_sr_b <= r_sr_b >> 1;
        r_cnt  <= r_cnt + CW'(1);
      end else if (w_stop) begin
        r_en  <= 1'b0;
        r_in1 <= 1'b0;
        r_in2 <= 1'b0;
        r_cnt <= '0;
      end
      // A refill on the same edge as a drain keeps HR occupied
      if (w_hr_wr) begin
        r_hr_a    <= op_a;
        r_hr_b    <= op_b;
        r_hr_full <= 1'b1;
      end else if (w_hr_clr) begin
        r_hr_full <= 1'b0;
      end
    end
  end

endmodule
